// File: rtl/oam_dma.sv
// oam_dma: sprite-attribute DMA engine. A CPU write to the trigger register
// halts the CPU and copies NUM_BYTES bytes from one 256-byte RAM page into the
// object buffer memory (OBM), one READ/WRITE cycle pair per byte.
module oam_dma #(
    parameter int NUM_BYTES = 256
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic [7:0]  data_i,
    input  logic        wen_i,
    input  logic        SELECT_dma_i,
    input  logic [7:0]  dma_data_i,
    output logic        cpu_rdy_o,
    output logic        bus_master_o,
    output logic [15:0] dma_address_o,
    output logic [7:0]  obm_address_o,
    output logic [7:0]  obm_data_o,
    output logic        obm_wen_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        READ,
        WRITE,
        DONE
    } state_t;

    // Index of the final byte. An 8-bit index covers the whole legal range
    // (1..256), and only ever forms address bits 7:0.
    localparam logic [7:0] LAST_INDEX = 8'(NUM_BYTES - 1);

    state_t     state;
    logic [7:0] page;
    logic [7:0] index;
    logic       trigger;

    // A CPU write that hits the DMA trigger register.
    assign trigger = SELECT_dma_i & wen_i;

    // Sequencer: every output is a register loaded with the value that belongs
    // to the state being entered, so nothing reaches a port combinationally.
    // obm_data_o doubles as the data register that captures the RAM byte.
    always_ff @(posedge cpu_clk) begin
        // NOTE: state and outputs are flops, so every update here is
        // non-blocking; each branch reads the pre-edge values of state/index.
        if (rst) begin
            // Reset wins over a trigger in the same cycle and aborts any
            // transfer on this edge; bytes already written stay in the OBM.
            state         <= IDLE;
            page          <= 8'h00;
            index         <= 8'h00;
            cpu_rdy_o     <= 1'b1;
            bus_master_o  <= 1'b0;
            dma_address_o <= 16'h0000;
            obm_address_o <= 8'h00;
            obm_data_o    <= 8'h00;
            obm_wen_o     <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page      <= data_i;
                        index     <= 8'h00;
                        state     <= ALIGN;
                        busy_o    <= 1'b1;
                        cpu_rdy_o <= 1'b0;
                    end
                end
                ALIGN: begin
                    // One dead cycle lets the CPU finish its halt before the
                    // DMA takes the address bus.
                    state         <= READ;
                    bus_master_o  <= 1'b1;
                    dma_address_o <= {page, index};
                end
                READ: begin
                    state         <= WRITE;
                    obm_data_o    <= dma_data_i;
                    obm_address_o <= index;
                    obm_wen_o     <= 1'b1;
                end
                WRITE: begin
                    obm_wen_o <= 1'b0;
                    if (index == LAST_INDEX) begin
                        state        <= DONE;
                        bus_master_o <= 1'b0;
                        done_o       <= 1'b1;
                    end else begin
                        // The increment is 8 bits wide, so the address never
                        // carries out of the latched page.
                        state         <= READ;
                        index         <= index + 8'd1;
                        dma_address_o <= {page, index + 8'd1};
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done_o    <= 1'b0;
                    busy_o    <= 1'b0;
                    cpu_rdy_o <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    bus_master_o <= 1'b0;
                    obm_wen_o    <= 1'b0;
                    busy_o       <= 1'b0;
                    done_o       <= 1'b0;
                    cpu_rdy_o    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 256, meaning bytes copied per transfer (64 objects x 4 bytes); legal range 1..256.
REQ-002 SHALL have port cpu_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port data_i  input  8  CPU write data; the source page number on trigger.
REQ-005 SHALL have port wen_i  input  1  CPU write enable, active-high.
REQ-006 SHALL have port SELECT_dma_i  input  1  address decode hit on the DMA trigger register.
REQ-007 SHALL have port dma_data_i  input  8  RAM read data during DMA reads.
REQ-008 SHALL have port cpu_rdy_o  output  1  CPU ready; low halts the CPU.
REQ-009 SHALL have port bus_master_o  output  1  DMA owns the address bus and RAM output enable.
REQ-010 SHALL have port dma_address_o  output  16  RAM read address.
REQ-011 SHALL have port obm_address_o  output  8  OBM byte address.
REQ-012 SHALL have port obm_data_o  output  8  OBM write data.
REQ-013 SHALL have port obm_wen_o  output  1  OBM write strobe, one cycle per byte.
REQ-014 SHALL have port busy_o  output  1  transfer in progress.
REQ-015 SHALL have port done_o  output  1  one-cycle pulse at transfer end.

Function
REQ-016 SHALL implement states IDLE, ALIGN, READ, WRITE, DONE.
REQ-017 SHALL treat trigger as SELECT_dma_i && wen_i sampled at a rising edge in IDLE: latch page <= data_i, index <= 0, next state ALIGN.
REQ-018 SHALL ignore triggers in any state other than IDLE, with no change to page, index or state.
REQ-019 SHALL in ALIGN: busy_o=1, cpu_rdy_o=0, bus_master_o=0, for exactly one cycle; next READ.
REQ-020 SHALL in READ: bus_master_o=1, dma_address_o={page,index}; capture dma_data_i into a data register at the end of the cycle; next WRITE.
REQ-021 SHALL in WRITE: bus_master_o=1, obm_wen_o=1, obm_address_o=index, obm_data_o=captured byte; if index==NUM_BYTES-1 next DONE, else index+1 and next READ.
REQ-022 SHALL use an index wide enough for NUM_BYTES-1, address bits 7:0 only; the RAM address SHALL never leave the latched page (page 8'hFF reads 16'hFF00..16'hFFFF; no carry into page).
REQ-023 SHALL in DONE: done_o=1, busy_o=1, cpu_rdy_o=0, bus_master_o=0, for one cycle; next IDLE.
REQ-024 SHALL in IDLE: busy_o=0, cpu_rdy_o=1, bus_master_o=0, obm_wen_o=0, done_o=0.
REQ-025 SHALL hold obm_wen_o=0 outside WRITE and bus_master_o=0 outside READ/WRITE.
REQ-026 SHALL give total busy time of exactly 2*NUM_BYTES+2 cycles (514 at default), trigger edge to return to IDLE.
REQ-027 SHALL drive dma_address_o, obm_address_o and obm_data_o from registers (no combinational path from data_i or dma_data_i).
REQ-028 SHALL accept a new trigger in the first IDLE cycle after DONE.

Reset
REQ-029 SHALL on rst=1 at a rising edge enter IDLE, clear page, index and data register to 0, and set the outputs cpu_rdy_o=1, all others 0.
REQ-030 SHALL abort a transfer on mid-operation reset in the same edge with no further OBM writes and no done_o pulse; already-written OBM bytes remain.
REQ-031 SHALL give rst priority over a trigger in the same cycle (trigger discarded).

Verification
REQ-032 SHALL cover a trigger with data_i=8'h02 and RAM[16'h0200+i]=i^8'hA5: 256 OBM writes, addr i, data i^8'hA5, done_o pulse at cycle 514, cpu_rdy_o low for cycles 1..514.
REQ-033 SHALL cover page 8'hFF: the last read address is 16'hFFFF, with no access to 16'h0000.
REQ-034 SHALL cover a second trigger at cycle 100 with data_i=8'h07: it is ignored, all reads stay in page 8'h02, and the length is unchanged.
REQ-035 SHALL cover rst asserted in the WRITE of index 9: the next cycle is IDLE, exactly 10 OBM writes (0..9) occurred, no done_o, and cpu_rdy_o=1.
REQ-036 SHALL cover a trigger in the first IDLE cycle after done_o: a new transfer starts, with ALIGN the next cycle.
REQ-037 SHALL cover NUM_BYTES=4: 4 writes with busy_o high for 10 cycles.
